// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: decode/execute hazard inputs and pipeline control outputs.
// The master side (pipeline or bench) drives the hazard terms; the slave side is the controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       IF_ID_RsAddr;
  logic [4:0]       IF_ID_RtAddr;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_MduAccess;
  logic             ID_Jump;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegWrAddr;
  logic             EX_MduStart;
  logic             EX_MduIsDiv;
  logic             EX_BranchTaken;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             MDU_Busy;
  logic             MDU_Done;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output IF_ID_RsAddr, IF_ID_RtAddr, ID_UsesRs, ID_UsesRt, ID_MduAccess, ID_Jump,
           ID_EX_MemRead, ID_EX_RegWrAddr, EX_MduStart, EX_MduIsDiv, EX_BranchTaken,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MDU_Busy, MDU_Done, StallCycles
  );

  modport slave (
    input  IF_ID_RsAddr, IF_ID_RtAddr, ID_UsesRs, ID_UsesRt, ID_MduAccess, ID_Jump,
           ID_EX_MemRead, ID_EX_RegWrAddr, EX_MduStart, EX_MduIsDiv, EX_BranchTaken,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MDU_Busy, MDU_Done, StallCycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use and MDU-occupancy stalls, branch/jump
// flushes, and a saturating count of stalled cycles.
module hazard_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [5:0]       w_cnt_nxt;
  logic             r_done;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu;
  logic w_mh;
  logic w_stall;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign w_lu = bus.ID_EX_MemRead && (bus.ID_EX_RegWrAddr != 5'd0) &&
                ((bus.ID_UsesRs && (bus.IF_ID_RsAddr == bus.ID_EX_RegWrAddr)) ||
                 (bus.ID_UsesRt && (bus.IF_ID_RtAddr == bus.ID_EX_RegWrAddr)));
  // On the final busy cycle (cnt==0) the result is ready, so the MDU access may issue.
  assign w_mh    = bus.ID_MduAccess &&
                   (((r_state == BUSY) && (r_cnt != 6'd0)) || bus.EX_MduStart);
  assign w_stall = (w_lu || w_mh) && !bus.EX_BranchTaken;

  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    if (reset) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (bus.EX_BranchTaken) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_stall) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end else if (bus.ID_Jump) begin
      w_if_id_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.EX_MduStart) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = bus.EX_MduIsDiv ? DIV_LD : MUL_LD;
        end
      end
      BUSY: begin
        if (r_cnt == 6'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 6'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 6'd0;
      r_done      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (r_state == BUSY) && (r_cnt == 6'd0);
      if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // A new MDU op while one is in flight is ignored; the interlock should prevent it.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
    (r_state == BUSY) |-> !bus.EX_MduStart);

  assign bus.PC_Write    = w_pc_write;
  assign bus.IF_ID_Write = w_if_id_write;
  assign bus.IF_ID_Flush = w_if_id_flush;
  assign bus.ID_EX_Flush = w_id_ex_flush;
  assign bus.MDU_Busy    = (r_state == BUSY);
  assign bus.MDU_Done    = r_done;
  assign bus.StallCycles = r_stall_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed hazard scenarios followed by random
// stimulus, all checked against a cycle-level reference model.
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 8;
  localparam int MULC  = 4;
  localparam int DIVC  = 32;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // Reference model state: remaining busy cycles, pending done pulse, stall count.
  int m_rem  = 0;
  int m_done = 0;
  int m_cnt  = 0;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus();

  hazard_stall_ctrl #(
    .MUL_CYCLES(MULC),
    .DIV_CYCLES(DIVC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check every output against the model, advance the model.
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic mdu, input logic jmp, input logic mr,
                     input logic [4:0] wa, input logic st, input logic dv, input logic br,
                     input logic rst);
    logic lu, mh, stall;
    logic e_pc, e_ifw, e_iff, e_idf;
    @(negedge clk);
    bus.IF_ID_RsAddr    = rs;
    bus.IF_ID_RtAddr    = rt;
    bus.ID_UsesRs       = urs;
    bus.ID_UsesRt       = urt;
    bus.ID_MduAccess    = mdu;
    bus.ID_Jump         = jmp;
    bus.ID_EX_MemRead   = mr;
    bus.ID_EX_RegWrAddr = wa;
    bus.EX_MduStart     = st;
    bus.EX_MduIsDiv     = dv;
    bus.EX_BranchTaken  = br;
    reset               = rst;
    #1;
    lu    = mr && (wa != 0) && ((urs && rs == wa) || (urt && rt == wa));
    mh    = mdu && ((m_rem > 1) || st);
    stall = (lu || mh) && !br;
    if (rst)        {e_pc, e_ifw, e_iff, e_idf} = 4'b0011;
    else if (br)    {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
    else if (stall) {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
    else if (jmp)   {e_pc, e_ifw, e_iff, e_idf} = 4'b1110;
    else            {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;
    chk("pc_write",    64'(bus.PC_Write),    64'(e_pc));
    chk("if_id_write", 64'(bus.IF_ID_Write), 64'(e_ifw));
    chk("if_id_flush", 64'(bus.IF_ID_Flush), 64'(e_iff));
    chk("id_ex_flush", 64'(bus.ID_EX_Flush), 64'(e_idf));
    chk("mdu_busy",    64'(bus.MDU_Busy),    64'(m_rem > 0));
    chk("mdu_done",    64'(bus.MDU_Done),    64'(m_done));
    chk("stall_cnt",   64'(bus.StallCycles), 64'(m_cnt));
    if (rst) begin
      m_rem = 0; m_done = 0; m_cnt = 0;
    end else begin
      m_done = (m_rem == 1);
      if (m_rem > 0) m_rem--;
      else if (st)   m_rem = dv ? DIVC : MULC;
      if (!e_pc && m_cnt < SAT) m_cnt++;
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ns, nd, c0, guard;
    logic hold;
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("reset_cnt", 64'(bus.StallCycles), 64'd0);

    // T1: lw $8 in EX, addu reading $8 in ID, then the stalled instruction proceeds.
    cyc(8, 9, 1, 1, 0, 0, 1, 8, 0, 0, 0, 0);
    chk("t1_stall", 64'(bus.PC_Write), 64'd0);
    cyc(8, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_go", 64'(bus.ID_EX_Flush), 64'd0);
    chk("t1_cnt", 64'(bus.StallCycles), 64'd1);

    // T2: load to $0 never stalls.
    cyc(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("t2_nostall", 64'(bus.PC_Write), 64'd1);

    // T3: div in EX with mflo waiting in ID.
    c0 = m_cnt;
    ns = 0; nd = 0; hold = 1'b1;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    if (!bus.PC_Write) ns++;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, hold, 0, 0, 0, 0, 0, 0, 0);
      if (!bus.PC_Write) ns++;
      else if (hold) begin
        chk("t3_issue_busy", 64'(bus.MDU_Busy), 64'd1);
        hold = 1'b0;
      end
      if (bus.MDU_Done) nd++;
    end
    chk("t3_stalls", 64'(ns), 64'd32);
    chk("t3_done", 64'(nd), 64'd1);
    chk("t3_cnt", 64'(m_cnt - c0), 64'd32);

    // T4: taken branch beats load-use stall and jump.
    c0 = m_cnt;
    cyc(3, 0, 1, 0, 0, 1, 1, 3, 0, 0, 1, 0);
    chk("t4_iff", 64'(bus.IF_ID_Flush), 64'd1);
    chk("t4_pc", 64'(bus.PC_Write), 64'd1);
    idle();
    chk("t4_cnt", 64'(bus.StallCycles), 64'(c0));

    // T5: jump alone.
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_idf", 64'(bus.ID_EX_Flush), 64'd0);
    idle();
    chk("t5_iff_off", 64'(bus.IF_ID_Flush), 64'd0);

    // T6: reset with 10 counts left in a div aborts it without a done pulse.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    guard = 0;
    while (m_rem != 11 && guard < 50) begin idle(); guard++; end
    chk("t6_reach", 64'(m_rem), 64'd11);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("t6_busy", 64'(bus.MDU_Busy), 64'd0);
    chk("t6_done", 64'(bus.MDU_Done), 64'd0);
    idle();
    chk("t6_done2", 64'(bus.MDU_Done), 64'd0);

    // Held load-use hazard drives the stall counter into saturation.
    for (int i = 0; i < SAT + 20; i++) cyc(5, 0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    idle();
    chk("sat", 64'(bus.StallCycles), 64'(SAT));

    // Random traffic; never starts an MDU op while the model says one is in flight.
    for (int i = 0; i < 3000; i++) begin
      logic st;
      st = (m_rem == 0) && ($urandom_range(0, 7) == 0);
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
          st, 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
